// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbiter.
package div_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int DEF_W    = 32;
    localparam int DEF_NREQ = 4;

    // Quotient reported for a divide-by-zero; wide enough for any W up to 64
    localparam logic [63:0] DIVZERO_Q = '1;

endpackage

// File: rtl/div_arbiter_rr_pick.sv
// Combinational round-robin picker: searches ptr+1, ptr+2, ... (mod N) and
// returns the first pending request as a one-hot grant plus its index.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    // First set bit after ptr, wrapping around
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (int'(ptr) + k) % N;
            if (!any && req[c]) begin
                any      = 1'b1;
                grant[c] = 1'b1;
                idx      = IW'(c);
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: shares one sequential divider between NREQ requesters with
// round-robin arbitration, one division in flight, divide-by-zero screening.
// Optional feature macro: DIV_ARB_TIMEOUT_EN (abort WAIT after TIMEOUT cycles).
//
// Handshake: a requester raises req_valid[i] with operands stable and holds
// them until it sees the one-cycle req_ready[i] pulse; dropping req_valid
// before that withdraws the request. The result comes back later as a
// one-cycle rsp_valid[i] pulse with rsp_q/rsp_r/rsp_err, which then hold
// their value until the next response. There is no back-pressure on rsp.
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int W       = DEF_W,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_y,
    input  logic [NREQ*W-1:0] req_x,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_q,
    output logic [W-1:0]      rsp_r,
    output logic              rsp_err,
    output logic              busy,
    output logic              div_en,
    output logic [W-1:0]      div_y,
    output logic [W-1:0]      div_x,
    input  logic [W-1:0]      div_q,
    input  logic [W-1:0]      div_r,
    input  logic              div_done
);

    localparam int IW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || W < 1 || W > 64 || TIMEOUT < 2) begin : g_bad_cfg
        $error("div_arbiter: unsupported NREQ/W/TIMEOUT");
    end

    state_t            state;
    state_t            state_nxt;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     g;
    logic [W-1:0]      lat_y;
    logic [W-1:0]      lat_x;
    logic [W-1:0]      res_q;
    logic [W-1:0]      res_r;
    logic              res_err;
    logic [NREQ-1:0]   pk_grant;
    logic [IW-1:0]     pk_idx;
    logic              pk_any;
    logic [W-1:0]      sel_y;
    logic [W-1:0]      sel_x;
    logic [NREQ-1:0]   req_ready_d;
    logic [NREQ-1:0]   rsp_valid_d;
    logic              div_en_d;
    logic              wait_expired;

    rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pk_grant),
        .idx   (pk_idx),
        .any   (pk_any)
    );

    assign sel_y = req_y[pk_idx*W +: W];
    assign sel_x = req_x[pk_idx*W +: W];

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] wait_cnt;

    // Cycles spent in WAIT for the current division
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == LOAD) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign wait_expired = (state == WAIT) && !div_done && (wait_cnt == CW'(TIMEOUT - 1));
`else
    assign wait_expired = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; div_done is deliberately not looked at in LOAD
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pk_any) begin
                    state_nxt = (sel_x == '0) ? RESP : LOAD;
                end
            end
            LOAD: state_nxt = WAIT;
            WAIT: begin
                if (div_done || wait_expired) begin
                    state_nxt = RESP;
                end
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered handshake outputs
    always_comb begin
        req_ready_d = '0;
        rsp_valid_d = '0;
        div_en_d    = 1'b0;
        if (state == IDLE && pk_any) begin
            req_ready_d = pk_grant;
            div_en_d    = (sel_x != '0);
        end
        if (state == RESP) begin
            rsp_valid_d[g] = 1'b1;
        end
    end

    // Grant bookkeeping, operand latch and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= IW'(NREQ - 1);
            g       <= '0;
            lat_y   <= '0;
            lat_x   <= '0;
            res_q   <= '0;
            res_r   <= '0;
            res_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pk_any) begin
                        g     <= pk_idx;
                        lat_y <= sel_y;
                        lat_x <= sel_x;
                        if (sel_x == '0) begin
                            res_q   <= W'(DIVZERO_Q);
                            res_r   <= sel_y;
                            res_err <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (div_done) begin
                        res_q   <= div_q;
                        res_r   <= div_r;
                        res_err <= 1'b0;
                    end else if (wait_expired) begin
                        res_q   <= '0;
                        res_r   <= '0;
                        res_err <= 1'b1;
                    end
                end
                RESP: ptr <= g;
                default: ;
            endcase
        end
    end

    // Registered outputs; response data holds between responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= '0;
            rsp_valid <= '0;
            div_en    <= 1'b0;
            rsp_q     <= '0;
            rsp_r     <= '0;
            rsp_err   <= 1'b0;
        end else begin
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            div_en    <= div_en_d;
            if (state == RESP) begin
                rsp_q   <= res_q;
                rsp_r   <= res_r;
                rsp_err <= res_err;
            end
        end
    end

    assign busy  = (state != IDLE);
    assign div_y = lat_y;
    assign div_x = lat_x;

endmodule
